perf_event_counters: RTL and testbench



---
 rtl/perf_event_counters.sv | 109 ++++++++++
 tb/tb_perf_event_counters.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_counters.sv
// Performance-event counter bank: eight saturating counters fed by commit and
// cache-request strobes, frozen once Halt commits, with a registered read port.
module perf_event_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             regWrite,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             halt,
    input  logic             iCacheReq,
    input  logic             iCacheHit,
    input  logic             dCacheReq,
    input  logic             dCacheHit,
    input  logic             rdReq,
    input  logic [2:0]       rdSel,
    output logic [CNT_W-1:0] rdData,
    output logic             rdValid,
    output logic             halted
);

    localparam int unsigned NumCnt = 8;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NumCnt];
    logic [CNT_W-1:0] cnt_d [NumCnt];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [NumCnt-1:0] ev;
    logic             counted;

    // Decode per-counter increment strobes; index matches the rdSel map.
    always_comb begin
        counted = enable & (state_q == StRun) & ~clear;
        ev      = '0;
        ev[0]   = 1'b1;
        ev[1]   = halt | regWrite | memWrite;
        ev[2]   = iCacheReq;
        ev[3]   = iCacheHit & iCacheReq;
        ev[4]   = dCacheReq;
        ev[5]   = dCacheHit & dCacheReq;
        ev[6]   = memRead;
        ev[7]   = (iCacheHit & ~iCacheReq) | (dCacheHit & ~dCacheReq);
    end

    // Run/halted next state; clear wins over a same-cycle halt.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StRun;
        end else if (counted && halt) begin
            state_d = StHalted;
        end
    end

    // Counter next state: clear drops the cycle's events, otherwise saturating increment.
    always_comb begin
        for (int i = 0; i < NumCnt; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i] = '0;
            end else if (counted && ev[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Read port samples the pre-update counter value; data holds when idle.
    always_comb begin
        rd_valid_d = rdReq;
        rd_data_d  = rd_data_q;
        if (rdReq) begin
            rd_data_d = cnt_q[rdSel];
        end
    end

    // State, counter and read-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rdData  = rd_data_q;
    assign rdValid = rd_valid_q;
    assign halted  = (state_q == StHalted);

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: table of drive/read records with a read
// scoreboard, plus hand sequences for saturation, clear races and async reset.
module tb_perf_event_counters;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0, clear = 1'b0;
    logic        regWrite = 1'b0, memRead = 1'b0, memWrite = 1'b0, halt = 1'b0;
    logic        iCacheReq = 1'b0, iCacheHit = 1'b0, dCacheReq = 1'b0, dCacheHit = 1'b0;
    logic        rdReq = 1'b0;
    logic [2:0]  rdSel = 3'd0;
    logic [31:0] rdData;
    logic        rdValid, halted;
    logic [7:0]  rdData8;
    logic        rdValid8, halted8;

    int total = 0;
    int bad   = 0;

    perf_event_counters #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .iCacheReq(iCacheReq), .iCacheHit(iCacheHit),
        .dCacheReq(dCacheReq), .dCacheHit(dCacheHit),
        .rdReq(rdReq), .rdSel(rdSel),
        .rdData(rdData), .rdValid(rdValid), .halted(halted)
    );

    perf_event_counters #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .iCacheReq(iCacheReq), .iCacheHit(iCacheHit),
        .dCacheReq(dCacheReq), .dCacheHit(dCacheHit),
        .rdReq(rdReq), .rdSel(rdSel),
        .rdData(rdData8), .rdValid(rdValid8), .halted(halted8)
    );

    always #5 clk = ~clk;

    // ev bits: halt, regWrite, memWrite, memRead, iCacheReq, iCacheHit, dCacheReq, dCacheHit
    typedef struct {
        bit          rd;
        bit          clr;
        bit          en;
        logic [7:0]  ev;
        int          n;
        logic [2:0]  sel;
        int unsigned exp;
        bit          exp_h;
    } vec_t;

    typedef struct {
        logic [31:0] e32;
        logic [7:0]  e8;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    logic [31:0] last32 = '0;
    logic [7:0]  last8  = '0;

    localparam logic [7:0] EvH  = 8'h80, EvRw = 8'h40, EvMw = 8'h20, EvMr = 8'h10;
    localparam logic [7:0] EvIr = 8'h08, EvIh = 8'h04, EvDr = 8'h02, EvDh = 8'h01;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_ev(input logic [7:0] ev);
        {halt, regWrite, memWrite, memRead, iCacheReq, iCacheHit, dCacheReq, dCacheHit} = ev;
    endtask

    task automatic push(input int unsigned exp);
        sb_t e;
        e.e32 = exp;
        e.e8  = (exp > 255) ? 8'hff : exp[7:0];
        sb.push_back(e);
    endtask

    // One clock: outputs checked on the falling edge after the active edge.
    task automatic step();
        logic req_b;
        sb_t  e;
        req_b = rdReq;
        @(posedge clk);
        @(negedge clk);
        chk("rdValid", {31'b0, rdValid}, {31'b0, req_b});
        chk("rdValid8", {31'b0, rdValid8}, {31'b0, req_b});
        if (req_b) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("rdData", rdData, e.e32);
                chk("rdData8", {24'b0, rdData8}, {24'b0, e.e8});
                last32 = e.e32;
                last8  = e.e8;
            end
        end else begin
            chk("rdHold", rdData, last32);
            chk("rdHold8", {24'b0, rdData8}, {24'b0, last8});
        end
    endtask

    task automatic add_drv(input bit clr, input bit en, input logic [7:0] ev, input int n,
                           input bit exp_h);
        vec_t v;
        v = '{rd: 1'b0, clr: clr, en: en, ev: ev, n: n, sel: 3'd0, exp: 0, exp_h: exp_h};
        tbl.push_back(v);
    endtask

    task automatic add_rd(input logic [2:0] sel, input int unsigned exp);
        vec_t v;
        v = '{rd: 1'b1, clr: 1'b0, en: 1'b0, ev: 8'h00, n: 1, sel: sel, exp: exp, exp_h: 1'b0};
        tbl.push_back(v);
    endtask

    initial begin
        // Idle counting from reset.
        add_drv(0, 1, 8'h00, 10, 0);
        add_rd(0, 10); add_rd(1, 0); add_rd(7, 0);
        // Instruction counting, enable gating.
        add_drv(1, 1, 8'h00, 1, 0);
        add_drv(0, 0, EvRw, 5, 0);
        add_drv(0, 1, EvRw, 3, 0);
        add_drv(0, 1, EvRw | EvMw, 2, 0);
        add_drv(0, 1, EvMw, 3, 0);
        add_rd(1, 8); add_rd(0, 8); add_rd(6, 0); add_rd(2, 0);
        // Cache requests/hits, protocol errors, loads.
        add_drv(1, 1, 8'h00, 1, 0);
        add_drv(0, 1, EvIr | EvIh, 4, 0);
        add_drv(0, 1, EvIr, 2, 0);
        add_drv(0, 1, EvIh, 1, 0);
        add_drv(0, 1, EvDr | EvDh, 3, 0);
        add_drv(0, 1, EvDr, 1, 0);
        add_drv(0, 1, EvDh, 2, 0);
        add_drv(0, 1, EvIh | EvDh, 1, 0);
        add_drv(0, 1, EvMr, 5, 0);
        add_rd(2, 6); add_rd(3, 4); add_rd(4, 4); add_rd(5, 3);
        add_rd(6, 5); add_rd(7, 4); add_rd(0, 19); add_rd(1, 0);
        // Halt freezes everything until clear.
        add_drv(1, 1, 8'h00, 1, 0);
        add_drv(0, 1, 8'h00, 4, 0);
        add_drv(0, 1, EvH, 1, 1);
        add_drv(0, 1, EvRw | EvIr | EvMr, 20, 1);
        add_rd(0, 5); add_rd(1, 1); add_rd(2, 0); add_rd(6, 0);
        add_drv(1, 1, 8'h00, 1, 0);
        add_rd(0, 0); add_rd(1, 0);
        // Halt without enable does not stop the block.
        add_drv(0, 0, EvH, 1, 0);
        add_rd(1, 0);

        // Reset state.
        #1 rst = 1'b1;
        #2;
        chk("rst_rdValid", {31'b0, rdValid}, 32'd0);
        chk("rst_rdData", rdData, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_rdData8", {24'b0, rdData8}, 32'd0);
        #4 rst = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rd) begin
                enable = 1'b0;
                clear  = 1'b0;
                set_ev(8'h00);
                rdReq  = 1'b1;
                rdSel  = tbl[i].sel;
                push(tbl[i].exp);
                step();
            end else begin
                rdReq  = 1'b0;
                clear  = tbl[i].clr;
                enable = tbl[i].en;
                set_ev(tbl[i].ev);
                repeat (tbl[i].n) step();
                chk("halted", {31'b0, halted}, {31'b0, tbl[i].exp_h});
                chk("halted8", {31'b0, halted8}, {31'b0, tbl[i].exp_h});
            end
        end
        rdReq = 1'b0;
        clear = 1'b0;
        set_ev(8'h00);
        step();

        // Saturation on the 8-bit instance, independent counters, read during clear.
        clear = 1'b1; enable = 1'b1; step();
        clear = 1'b0;
        repeat (300) step();
        chk("sat_halted", {31'b0, halted}, 32'd0);
        enable = 1'b0; rdReq = 1'b1; rdSel = 3'd1; push(0); step();
        rdSel = 3'd0; clear = 1'b1; enable = 1'b1; push(300); step();
        clear = 1'b0; enable = 1'b0; push(0); step();
        rdReq = 1'b0; clear = 1'b1; enable = 1'b1; regWrite = 1'b1; step();
        clear = 1'b0; enable = 1'b0; regWrite = 1'b0;
        rdReq = 1'b1; rdSel = 3'd1; push(0); step();
        rdSel = 3'd0; push(0); step();
        rdReq = 1'b0; step();

        // Asynchronous reset while a read result is on the port.
        clear = 1'b1; enable = 1'b1; step();
        clear = 1'b0;
        repeat (3) step();
        halt = 1'b1; step();
        halt = 1'b0; enable = 1'b0;
        chk("pre_rst_halted", {31'b0, halted}, 32'd1);
        rdReq = 1'b1; rdSel = 3'd0;
        @(posedge clk);
        #1;
        chk("pre_rst_rdValid", {31'b0, rdValid}, 32'd1);
        chk("pre_rst_rdData", rdData, 32'd4);
        rdReq = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rdValid", {31'b0, rdValid}, 32'd0);
        chk("async_rdData", rdData, 32'd0);
        chk("async_halted", {31'b0, halted}, 32'd0);
        chk("async_rdValid8", {31'b0, rdValid8}, 32'd0);
        chk("async_rdData8", {24'b0, rdData8}, 32'd0);
        chk("async_halted8", {31'b0, halted8}, 32'd0);
        last32 = '0;
        last8  = '0;
        #1 rst = 1'b0;
        rdReq = 1'b1; rdSel = 3'd0; push(0); step();
        rdSel = 3'd1; push(0); step();
        rdReq = 1'b0; step();

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
